// File: rtl/mem_access.sv
// Memory-access pipeline stage: drives a req/addr_ok/data_ok SRAM-like bus, aligns store lanes,
// extends load data, flags misaligned accesses and stalls upstream until the access completes.
module mem_access #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid_i,
  input  logic [3:0]    mem_memop_i,
  input  logic [31:0]   mem_aluout_i,
  input  logic [31:0]   mem_wdata_i,
  input  logic [31:0]   mem_excepttype_i,
  input  logic          mem_flush_i,
  input  logic          pipe_adv_i,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  output logic [3:0]    data_wstrb,
  output logic [31:0]   data_wdata,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [31:0]   data_rdata,
  output logic [31:0]   mem_result_o,
  output logic [31:0]   mem_excepttype_o,
  output logic [31:0]   mem_badvaddr_o,
  output logic          mem_stall_o
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StCancel, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] ld_buf_q, ld_buf_d;

  logic        op_ld, op_st, op_sext;
  logic [1:0]  op_size;
  logic [1:0]  lane;
  logic        addr_err, launch;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;

  assign lane = mem_aluout_i[1:0];

  always_comb begin
    op_ld   = 1'b0;
    op_st   = 1'b0;
    op_sext = 1'b0;
    op_size = 2'd0;
    case (mem_memop_i)
      4'd1:    begin op_ld = 1'b1; op_sext = 1'b1; op_size = 2'd0; end
      4'd2:    begin op_ld = 1'b1; op_size = 2'd0; end
      4'd3:    begin op_ld = 1'b1; op_sext = 1'b1; op_size = 2'd1; end
      4'd4:    begin op_ld = 1'b1; op_size = 2'd1; end
      4'd5:    begin op_ld = 1'b1; op_size = 2'd2; end
      4'd6:    begin op_st = 1'b1; op_size = 2'd0; end
      4'd7:    begin op_st = 1'b1; op_size = 2'd1; end
      4'd8:    begin op_st = 1'b1; op_size = 2'd2; end
      default: ;
    endcase
  end

  assign addr_err = mem_valid_i && (op_ld || op_st) &&
                    ((op_size == 2'd1 && lane[0]) || (op_size == 2'd2 && lane != 2'd0));

  // rst is folded in so no request leaks onto the bus while reset is held.
  assign launch = rst && mem_valid_i && (op_ld || op_st) && (mem_excepttype_i == 32'd0) &&
                  !addr_err && !mem_flush_i;

  always_comb begin
    rd_byte = data_rdata[7:0];
    case (lane)
      2'd1:    rd_byte = data_rdata[15:8];
      2'd2:    rd_byte = data_rdata[23:16];
      2'd3:    rd_byte = data_rdata[31:24];
      default: ;
    endcase
    rd_half = lane[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (op_size)
      2'd0:    ld_ext = {{24{op_sext & rd_byte[7]}}, rd_byte};
      2'd1:    ld_ext = {{16{op_sext & rd_half[15]}}, rd_half};
      default: ld_ext = data_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ld_buf_d    = ld_buf_q;
    data_req    = 1'b0;
    mem_stall_o = 1'b0;
    case (state_q)
      StIdle: begin
        data_req    = launch;
        mem_stall_o = launch;
        if (launch) state_d = data_addr_ok ? StWait : StReq;
      end
      StReq: begin
        data_req    = 1'b1;
        mem_stall_o = 1'b1;
        // An accepted request still owes a data_ok even if flushed in the same cycle.
        if (data_addr_ok)     state_d = mem_flush_i ? StCancel : StWait;
        else if (mem_flush_i) state_d = StIdle;
      end
      StWait: begin
        mem_stall_o = 1'b1;
        if (data_data_ok) begin
          if (mem_flush_i) begin
            state_d = StIdle;
          end else begin
            ld_buf_d = ld_ext;
            state_d  = StDone;
          end
        end else if (mem_flush_i) begin
          state_d = StCancel;
        end
      end
      StCancel: begin
        mem_stall_o = 1'b1;
        if (data_data_ok) state_d = StIdle;
      end
      StDone: begin
        if (pipe_adv_i || mem_flush_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ld_buf_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      ld_buf_q <= ld_buf_d;
    end
  end

  // Bus fields are zeroed whenever no request is presented.
  always_comb begin
    data_wr    = data_req && op_st;
    data_size  = data_req ? op_size : 2'd0;
    data_addr  = data_req ? AW'(mem_aluout_i) : '0;
    data_wstrb = 4'b0000;
    data_wdata = 32'd0;
    if (data_req && op_st) begin
      case (op_size)
        2'd0: begin
          data_wstrb = 4'b0001 << lane;
          data_wdata = {4{mem_wdata_i[7:0]}};
        end
        2'd1: begin
          data_wstrb = lane[1] ? 4'b1100 : 4'b0011;
          data_wdata = {2{mem_wdata_i[15:0]}};
        end
        default: begin
          data_wstrb = 4'b1111;
          data_wdata = mem_wdata_i;
        end
      endcase
    end
  end

  always_comb begin
    mem_excepttype_o = mem_excepttype_i;
    mem_badvaddr_o   = 32'd0;
    if (mem_excepttype_i == 32'd0 && addr_err) begin
      mem_excepttype_o = op_ld ? 32'h04 : 32'h05;
      mem_badvaddr_o   = mem_aluout_i;
    end
    mem_result_o = (state_q == StDone && op_ld) ? ld_buf_q : mem_aluout_i;
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, handshake corner sequences and
// randomized accesses checked against an arithmetic reference model.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_i;
  logic [3:0]  mem_memop_i;
  logic [31:0] mem_aluout_i, mem_wdata_i, mem_excepttype_i;
  logic        mem_flush_i, pipe_adv_i;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] mem_result_o, mem_excepttype_o, mem_badvaddr_o;
  logic        mem_stall_o;

  int checks = 0;
  int errors = 0;
  int outstanding = 0;

  always #5 clk = ~clk;

  mem_access #(.AW(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_valid_i      (mem_valid_i),
    .mem_memop_i      (mem_memop_i),
    .mem_aluout_i     (mem_aluout_i),
    .mem_wdata_i      (mem_wdata_i),
    .mem_excepttype_i (mem_excepttype_i),
    .mem_flush_i      (mem_flush_i),
    .pipe_adv_i       (pipe_adv_i),
    .data_req         (data_req),
    .data_wr          (data_wr),
    .data_size        (data_size),
    .data_addr        (data_addr),
    .data_wstrb       (data_wstrb),
    .data_wdata       (data_wdata),
    .data_addr_ok     (data_addr_ok),
    .data_data_ok     (data_data_ok),
    .data_rdata       (data_rdata),
    .mem_result_o     (mem_result_o),
    .mem_excepttype_o (mem_excepttype_o),
    .mem_badvaddr_o   (mem_badvaddr_o),
    .mem_stall_o      (mem_stall_o)
  );

  // Bus-side view: data_ok is only legal while a transaction is outstanding.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding = 0;
    end else begin
      if (data_data_ok) begin
        checks++;
        assert (outstanding > 0) else begin
          errors++;
          $display("FAIL protocol: data_ok with %0d outstanding, required >0", outstanding);
        end
        if (outstanding > 0) outstanding--;
      end
      if (data_req && data_addr_ok) outstanding++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic over the access rules.
  function automatic bit ref_is_load(int op);
    return op >= 1 && op <= 5;
  endfunction

  function automatic bit ref_is_mem(int op);
    return op >= 1 && op <= 8;
  endfunction

  function automatic int ref_bytes(int op);
    if (op == 1 || op == 2 || op == 6) return 1;
    if (op == 3 || op == 4 || op == 7) return 2;
    if (op == 5 || op == 8) return 4;
    return 0;
  endfunction

  function automatic bit ref_fault(int op, logic [31:0] addr);
    int nb = ref_bytes(op);
    return nb > 1 && (addr % nb) != 0;
  endfunction

  function automatic logic [31:0] ref_load(int op, logic [31:0] rd, logic [31:0] addr);
    longint v;
    int a = int'(addr % 4);
    v = 0;
    if (op == 1 || op == 2) begin
      v = (rd >> (8 * a)) & 32'hFF;
      if (op == 1 && v >= 128) v = v - 256;
    end else if (op == 3 || op == 4) begin
      v = (rd >> (16 * (a / 2))) & 32'hFFFF;
      if (op == 3 && v >= 32768) v = v - 65536;
    end else if (op == 5) begin
      v = rd;
    end
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_wstrb(int op, logic [31:0] addr);
    int a = int'(addr % 4);
    if (op < 6 || op > 8) return 4'd0;
    return 4'((2 ** ref_bytes(op) - 1) << a);
  endfunction

  function automatic logic [31:0] ref_wdata(int op, logic [31:0] w);
    if (op == 6) return (w % 256) * 32'h01010101;
    if (op == 7) return (w % 65536) * 32'h00010001;
    if (op == 8) return w;
    return 32'd0;
  endfunction

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exc_in;
    int          ao;
    int          dly;
    logic [31:0] exp_result;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_exc;
  } vec_t;

  // Runs one access starting from IDLE with inputs driven at posedge+1.
  task automatic apply_vec(input vec_t v);
    bit req_exp;
    int stalls;
    int size_exp;
    req_exp = v.exp_exc == 0 && ref_is_mem(v.op);
    size_exp = ref_bytes(v.op) / 2;
    mem_valid_i      = 1'b1;
    mem_memop_i      = 4'(v.op);
    mem_aluout_i     = v.addr;
    mem_wdata_i      = v.wdata;
    mem_excepttype_i = v.exc_in;
    data_addr_ok     = (v.ao == 0);
    data_data_ok     = 1'b0;
    #1;
    chk("excepttype", mem_excepttype_o, v.exp_exc);
    if (v.exc_in == 0 && (v.exp_exc == 32'h4 || v.exp_exc == 32'h5))
      chk("badvaddr", mem_badvaddr_o, v.addr);
    if (!req_exp) begin
      chk("no_req", 32'(data_req), 32'd0);
      chk("no_stall", 32'(mem_stall_o), 32'd0);
      chk("passthru", mem_result_o, v.addr);
      step();
      mem_valid_i = 1'b0;
      mem_memop_i = 4'd0;
      mem_excepttype_i = 32'd0;
      return;
    end
    chk("req", 32'(data_req), 32'd1);
    chk("wr", 32'(data_wr), 32'(v.op >= 6));
    chk("size", 32'(data_size), 32'(size_exp));
    chk("wstrb", 32'(data_wstrb), 32'(v.exp_wstrb));
    chk("wdata", data_wdata, v.exp_wdata);
    stalls = int'(mem_stall_o);
    for (int i = 1; i <= v.ao; i++) begin
      step();
      data_addr_ok = (i == v.ao);
      #1;
      chk("req_held", 32'(data_req), 32'd1);
      chk("addr_held", data_addr, v.addr);
      chk("wstrb_held", 32'(data_wstrb), 32'(v.exp_wstrb));
      stalls += int'(mem_stall_o);
    end
    step();
    data_addr_ok = 1'b0;
    for (int j = 1; j <= v.dly; j++) begin
      data_data_ok = (j == v.dly);
      data_rdata   = (j == v.dly) ? v.rdata : ~v.rdata;
      #1;
      chk("req_wait", 32'(data_req), 32'd0);
      stalls += int'(mem_stall_o);
      step();
    end
    data_data_ok = 1'b0;
    #1;
    chk("done_stall", 32'(mem_stall_o), 32'd0);
    chk("result", mem_result_o, v.exp_result);
    chk("stall_cycles", 32'(stalls), 32'(1 + v.ao + v.dly));
    pipe_adv_i = 1'b1;
    step();
    pipe_adv_i  = 1'b0;
    mem_valid_i = 1'b0;
    #1;
    chk("back_idle", mem_result_o, v.addr);
    mem_memop_i = 4'd0;
  endtask

  vec_t tbl [$];
  vec_t rv;

  initial begin
    rst = 1'b0;
    mem_valid_i = 1'b0; mem_memop_i = 4'd0; mem_aluout_i = 32'd0; mem_wdata_i = 32'd0;
    mem_excepttype_i = 32'd0; mem_flush_i = 1'b0; pipe_adv_i = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;

    //         op addr          wdata         rdata         exc ao dly result       wstrb    wdata        exc
    tbl.push_back('{5, 32'h80001004, 32'h0, 32'hDEADBEEF, 32'h0, 0, 1, 32'hDEADBEEF, 4'b0000,
                    32'h0, 32'h0});
    tbl.push_back('{1, 32'h80000003, 32'h0, 32'h80FF0000, 32'h0, 0, 1, 32'hFFFFFF80, 4'b0000,
                    32'h0, 32'h0});
    tbl.push_back('{2, 32'h80000003, 32'h0, 32'h80FF0000, 32'h0, 0, 1, 32'h00000080, 4'b0000,
                    32'h0, 32'h0});
    tbl.push_back('{3, 32'h80000002, 32'h0, 32'h80FF0000, 32'h0, 0, 1, 32'hFFFF80FF, 4'b0000,
                    32'h0, 32'h0});
    tbl.push_back('{4, 32'h80000000, 32'h0, 32'h80FF0000, 32'h0, 0, 1, 32'h00000000, 4'b0000,
                    32'h0, 32'h0});
    tbl.push_back('{7, 32'h80000002, 32'h1234ABCD, 32'h0, 32'h0, 0, 1, 32'h80000002, 4'b1100,
                    32'hABCDABCD, 32'h0});
    tbl.push_back('{6, 32'h80000001, 32'h000000A5, 32'h0, 32'h0, 1, 1, 32'h80000001, 4'b0010,
                    32'hA5A5A5A5, 32'h0});
    tbl.push_back('{5, 32'h80000002, 32'h0, 32'h0, 32'h0, 0, 1, 32'h80000002, 4'b0000,
                    32'h0, 32'h4});
    tbl.push_back('{7, 32'h80000001, 32'h0, 32'h0, 32'h0, 0, 1, 32'h80000001, 4'b0000,
                    32'h0, 32'h5});
    tbl.push_back('{5, 32'h80000010, 32'h0, 32'h01234567, 32'h0, 3, 2, 32'h01234567, 4'b0000,
                    32'h0, 32'h0});
    tbl.push_back('{8, 32'h8000000C, 32'hCAFEF00D, 32'h0, 32'h0, 0, 1, 32'h8000000C, 4'b1111,
                    32'hCAFEF00D, 32'h0});
    tbl.push_back('{5, 32'h80000020, 32'h0, 32'h0, 32'hC, 0, 1, 32'h80000020, 4'b0000,
                    32'h0, 32'hC});
    tbl.push_back('{0, 32'h12345678, 32'h0, 32'h0, 32'h0, 0, 1, 32'h12345678, 4'b0000,
                    32'h0, 32'h0});
    tbl.push_back('{12, 32'h00000003, 32'h0, 32'h0, 32'h0, 0, 1, 32'h00000003, 4'b0000,
                    32'h0, 32'h0});

    #1;
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_stall", 32'(mem_stall_o), 32'd0);
    chk("rst_wstrb", 32'(data_wstrb), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    foreach (tbl[k]) apply_vec(tbl[k]);

    // Flush while the request is still unaccepted.
    mem_valid_i = 1'b1; mem_memop_i = 4'd8; mem_aluout_i = 32'h80005000; data_addr_ok = 1'b0;
    #1 chk("req_flush_pre", 32'(data_req), 32'd1);
    step();
    mem_flush_i = 1'b1;
    #1 chk("req_in_req", 32'(data_req), 32'd1);
    step();
    mem_flush_i = 1'b0; mem_valid_i = 1'b0;
    #1;
    chk("req_dropped", 32'(data_req), 32'd0);
    chk("req_flush_stall", 32'(mem_stall_o), 32'd0);
    chk("req_flush_no_txn", 32'(outstanding), 32'd0);
    step();

    // Flush while waiting, data arrives two cycles later and must be discarded.
    mem_valid_i = 1'b1; mem_memop_i = 4'd5; mem_aluout_i = 32'h80002000; data_addr_ok = 1'b1;
    #1 chk("cancel_launch", 32'(data_req), 32'd1);
    step();
    data_addr_ok = 1'b0; mem_flush_i = 1'b1;
    #1 chk("cancel_wait_stall", 32'(mem_stall_o), 32'd1);
    step();
    mem_flush_i = 1'b0; mem_valid_i = 1'b0;
    #1 chk("cancel_stall", 32'(mem_stall_o), 32'd1);
    step();
    data_data_ok = 1'b1; data_rdata = 32'h11111111;
    mem_valid_i = 1'b1; mem_memop_i = 4'd5; mem_aluout_i = 32'h80003000;
    #1;
    chk("cancel_no_new_req", 32'(data_req), 32'd0);
    chk("cancel_stall_ok", 32'(mem_stall_o), 32'd1);
    step();
    data_data_ok = 1'b0; data_addr_ok = 1'b1;
    #1 chk("relaunch_req", 32'(data_req), 32'd1);
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h22222222;
    step();
    data_data_ok = 1'b0;
    #1;
    chk("relaunch_stall", 32'(mem_stall_o), 32'd0);
    chk("relaunch_result", mem_result_o, 32'h22222222);
    pipe_adv_i = 1'b1;
    step();
    pipe_adv_i = 1'b0; mem_valid_i = 1'b0;
    step();

    // data_ok coincident with flush in WAIT returns straight to IDLE.
    mem_valid_i = 1'b1; mem_memop_i = 4'd5; mem_aluout_i = 32'h80004000; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; mem_flush_i = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h33333333;
    step();
    mem_flush_i = 1'b0; data_data_ok = 1'b0; mem_valid_i = 1'b0;
    #1;
    chk("okflush_stall", 32'(mem_stall_o), 32'd0);
    chk("okflush_result", mem_result_o, 32'h80004000);
    step();

    // Asynchronous reset in the middle of WAIT.
    mem_valid_i = 1'b1; mem_memop_i = 4'd8; mem_aluout_i = 32'h80006000;
    mem_wdata_i = 32'h55AA55AA; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    #1 chk("arst_pre_stall", 32'(mem_stall_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_req", 32'(data_req), 32'd0);
    chk("arst_stall", 32'(mem_stall_o), 32'd0);
    chk("arst_wstrb", 32'(data_wstrb), 32'd0);
    chk("arst_wdata", data_wdata, 32'd0);
    mem_valid_i = 1'b0;
    step();
    rst = 1'b1;
    #1 chk("arst_idle_stall", 32'(mem_stall_o), 32'd0);
    step();

    // Randomized accesses against the reference model.
    for (int n = 0; n < 60; n++) begin
      rv.op     = int'($urandom_range(0, 10));
      rv.addr   = $urandom;
      if ($urandom_range(0, 1) == 1) rv.addr[1:0] = 2'b00;
      rv.wdata  = $urandom;
      rv.rdata  = $urandom;
      rv.exc_in = ($urandom_range(0, 7) == 0) ? 32'hC : 32'h0;
      rv.ao     = int'($urandom_range(0, 2));
      rv.dly    = int'($urandom_range(1, 2));
      if (rv.exc_in != 0)                       rv.exp_exc = rv.exc_in;
      else if (ref_fault(rv.op, rv.addr))       rv.exp_exc = ref_is_load(rv.op) ? 32'h4 : 32'h5;
      else                                      rv.exp_exc = 32'h0;
      rv.exp_result = (rv.exp_exc == 0 && ref_is_load(rv.op)) ?
                      ref_load(rv.op, rv.rdata, rv.addr) : rv.addr;
      rv.exp_wstrb  = ref_wstrb(rv.op, rv.addr);
      rv.exp_wdata  = ref_wdata(rv.op, rv.wdata);
      apply_vec(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the EX/MEM register contents (ALU result as address or as pass-through value, store data, memory op) and drives an SRAM-like data bus with a req/addr_ok/data_ok handshake.
- Generates the byte strobes and lane-replicated store data, sign- or zero-extends load data, and detects address-error exceptions.
- Holds the pipeline via mem_stall_o until the access completes.

Parameters:
- AW, 32, data bus address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- mem_valid_i  in  1  stage holds a live instruction
- mem_memop_i  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; others behave as none
- mem_aluout_i  in  32  address, or result for non-memory ops
- mem_wdata_i  in  32  store data (forwarded rt)
- mem_excepttype_i  in  32  exception code from earlier stages; nonzero suppresses the access
- mem_flush_i  in  1  pipeline flush
- pipe_adv_i  in  1  EX/MEM register loads a new instruction at this edge
- data_req  out  1  request
- data_wr  out  1  1 = store
- data_size  out  2  0 byte, 1 half, 2 word
- data_addr  out  AW  byte address, unmodified
- data_wstrb  out  4  byte enables
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  request accepted
- data_data_ok  in  1  read data valid / write complete
- data_rdata  in  32  read data
- mem_result_o  out  32  extended load data, else mem_aluout_i
- mem_excepttype_o  out  32  mem_excepttype_i, or 0x04 AdEL / 0x05 AdES
- mem_badvaddr_o  out  32  faulting address
- mem_stall_o  out  1  hold upstream stages

Behaviour:
- Reset (rst=0, async): FSM=IDLE, load buffer=0, data_req=0; all registered outputs 0.
- Address error, combinational, takes priority over bus access:
  - LH/LHU/SH with addr[0]=1 → fault.
  - LW/SW with addr[1:0]≠0 → fault.
  - Loads report 0x04; stores report 0x05; mem_badvaddr_o=addr.
  - No request is issued for a faulting access.
- Access launches only when: mem_valid_i=1, memop in 1..8, mem_excepttype_i=0, no address error, mem_flush_i=0.
- FSM states:
  - IDLE: if launch, data_req=1 combinationally. If data_addr_ok that cycle, go to WAIT; else go to REQ. mem_stall_o=launch.
  - REQ: data_req=1, request fields held stable. On addr_ok go to WAIT. On mem_flush_i go to IDLE; the request is dropped the next cycle and was never accepted.
  - WAIT: data_req=0, mem_stall_o=1. On data_ok, capture data_rdata into the load buffer and go to DONE. If mem_flush_i arrives while in WAIT, go to CANCEL.
  - CANCEL: mem_stall_o=1, no new request. On data_ok, discard the data and go to IDLE.
  - DONE: mem_stall_o=0, mem_result_o taken from the buffer. On pipe_adv_i or mem_flush_i go to IDLE.
- data_ok arriving in the same cycle as mem_flush_i in WAIT: the data is discarded and the FSM goes to IDLE.
- Exactly one outstanding transaction. data_ok in IDLE/REQ/DONE is ignored; this is a protocol error and fires a bench assertion.
- Store lanes (a = addr[1:0]):
  - SB: wdata={4{wdata[7:0]}}, wstrb=4'b0001<<a.
  - SH: wdata={2{wdata[15:0]}}, wstrb = a[1] ? 1100 : 0011.
  - SW: wstrb=1111.
  - Loads: wstrb=0000.
- Load extract: byte lane = a, half lane = a[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Stores complete on data_ok but produce no load data; mem_result_o=mem_aluout_i.
- Minimum latency: addr_ok and data_ok one cycle apart gives 2 stall cycles, then DONE.

Test Plan:
- LW addr 0x80001004, addr_ok same cycle, data_ok 1 cycle later with rdata 0xDEADBEEF → stall 2 cycles, mem_result_o=0xDEADBEEF, FSM DONE, IDLE after pipe_adv_i.
- LB addr ..03 rdata 0x80FF_0000 → 0xFFFFFF80. LBU same → 0x00000080. LH addr ..02 → 0xFFFF80FF. LHU addr ..00 → 0x00000000.
- SH addr ..02 wdata 0x1234ABCD → data_wr=1, size=1, wstrb=1100, wdata=0xABCDABCD. SB addr ..01 → wstrb=0010.
- LW addr ..02 → no data_req, excepttype_o=0x04, badvaddr_o=addr, stall 0. SH addr ..01 → 0x05.
- addr_ok withheld 3 cycles → data_req and fields stable for 4 cycles. Flush in REQ → req deasserted next cycle, no transaction.
- Flush in WAIT, data_ok 2 cycles later → stall held through CANCEL, data discarded, next LW launches only after IDLE. Async rst low mid-WAIT → all outputs 0 immediately.
